// File: rtl/tracker_pkg.sv
// Shared types and constants for the ball-tracker overlay path.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a; no ports, imported by the renderer, its border detector and the interface.
package tracker_pkg;

  // Visible raster and the one-per-frame commit coordinate (first blanked line).
  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [9:0] COMMIT_Y = 10'd480;
  localparam logic [9:0] H_LAST   = 10'd639;
  localparam logic [9:0] V_LAST   = 10'd479;

  // Search window limits, kept a few pixels inside the frame.
  localparam logic signed [11:0] WIN_X_MIN = 12'sd5;
  localparam logic signed [11:0] WIN_X_MAX = 12'sd634;
  localparam logic signed [11:0] WIN_Y_MIN = 12'sd5;
  localparam logic signed [11:0] WIN_Y_MAX = 12'sd474;

  localparam logic [9:0] C_ZERO = 10'd0;
  localparam logic [9:0] C_FULL = 10'd1023;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    COAST  = 2'd2
  } trk_state_t;

  typedef struct packed {
    logic [9:0] tlx;
    logic [9:0] tly;
    logic [9:0] brx;
    logic [9:0] bry;
  } box_t;

  // Field order is tlx, tly, brx, bry (MSB first).
  localparam box_t WIN_FULL = {10'd5, 10'd5, 10'd634, 10'd474};

  // A box is usable only if it is non-degenerate and fully on screen.
  // tlx > brx is how a tracker underflow shows up, so it must be rejected.
  function automatic logic box_ok(input box_t b);
    return (b.tlx < b.brx) && (b.tly < b.bry) && (b.brx <= H_LAST) && (b.bry <= V_LAST);
  endfunction

  function automatic logic [9:0] clamp(input logic signed [11:0] v,
                                       input logic signed [11:0] lo,
                                       input logic signed [11:0] hi);
    logic signed [11:0] r;
    r = v;
    if (v < lo) r = lo;
    if (v > hi) r = hi;
    return r[9:0];
  endfunction

  // Expand a box by m on every side; arithmetic is signed so that a box
  // touching the frame edge clamps instead of wrapping.
  function automatic box_t win_of(input box_t b, input logic signed [11:0] m);
    box_t w;
    w.tlx = clamp($signed({2'b00, b.tlx}) - m, WIN_X_MIN, WIN_X_MAX);
    w.tly = clamp($signed({2'b00, b.tly}) - m, WIN_Y_MIN, WIN_Y_MAX);
    w.brx = clamp($signed({2'b00, b.brx}) + m, WIN_X_MIN, WIN_X_MAX);
    w.bry = clamp($signed({2'b00, b.bry}) + m, WIN_Y_MIN, WIN_Y_MAX);
    return w;
  endfunction

endpackage

// File: rtl/box_overlay_renderer_if.sv
// Pixel/box/overlay bundle between the tracker-side producer and the overlay renderer.
// Latency: n/a (wires only).
// Backpressure: none; pixel stream and box strobe are free-running, one beat per CLK.
// Ports (slave view): DrawX/DrawY/VGA_R/G/B/detect pixel in, box_we + box_* box in,
//   Red/Green/Blue overlay out, Tlx/Tly/Brx/Bry search window out, tracking status out.
interface box_overlay_renderer_if;

  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [9:0] VGA_R;
  logic [9:0] VGA_G;
  logic [9:0] VGA_B;
  logic       detect;
  logic       box_we;
  logic [9:0] box_tlx;
  logic [9:0] box_tly;
  logic [9:0] box_brx;
  logic [9:0] box_bry;
  logic [9:0] Red;
  logic [9:0] Green;
  logic [9:0] Blue;
  logic [9:0] Tlx;
  logic [9:0] Tly;
  logic [9:0] Brx;
  logic [9:0] Bry;
  logic       tracking;

  modport master (
    output DrawX, DrawY, VGA_R, VGA_G, VGA_B, detect,
    output box_we, box_tlx, box_tly, box_brx, box_bry,
    input  Red, Green, Blue, Tlx, Tly, Brx, Bry, tracking
  );

  modport slave (
    input  DrawX, DrawY, VGA_R, VGA_G, VGA_B, detect,
    input  box_we, box_tlx, box_tly, box_brx, box_bry,
    output Red, Green, Blue, Tlx, Tly, Brx, Bry, tracking
  );

endinterface

// File: rtl/box_border_detect.sv
// Flags pixels lying on the THICK-pixel outline drawn just inside a box.
// Latency: combinational.
// Backpressure: none.
// Ports: box (active box), x/y (current pixel) -> hit.
module box_border_detect
  import tracker_pkg::*;
#(
  parameter int THICK = 2
) (
  input  box_t       box,
  input  logic [9:0] x,
  input  logic [9:0] y,
  output logic       hit
);

  localparam logic [10:0] T = 11'(THICK);

  logic [10:0] xe;
  logic [10:0] ye;
  logic        in_box;
  logic        on_edge;

  assign xe = {1'b0, x};
  assign ye = {1'b0, y};

  assign in_box = (x >= box.tlx) && (x <= box.brx) && (y >= box.tly) && (y <= box.bry);

  // "x > brx-THICK" is written as "x+THICK > brx" so small boxes cannot underflow.
  // A box narrower than 2*THICK satisfies one of the terms everywhere -> solid.
  assign on_edge = (xe < ({1'b0, box.tlx} + T)) || ((xe + T) > {1'b0, box.brx}) ||
                   (ye < ({1'b0, box.tly} + T)) || ((ye + T) > {1'b0, box.bry});

  assign hit = in_box && on_edge;

endmodule

// File: rtl/box_overlay_renderer.sv
// Validates/debounces the per-frame tracker box, outlines it over the camera stream, and feeds back a search window.
// Latency: pixel colour 1 CLK; box/state/window change once per frame at the commit pixel (0,480).
// Backpressure: none; every pixel is accepted, a box strobe simply overwrites the shadow box.
// Ports: CLK, RESET (sync, active-high), bus (slave modport of box_overlay_renderer_if).
module box_overlay_renderer
  import tracker_pkg::*;
#(
  parameter int THICK       = 2,
  parameter int MARGIN      = 16,
  parameter int ACQ_FRAMES  = 3,
  parameter int LOST_FRAMES = 8,
  parameter int DEBUG_EN    = 1
) (
  input  logic                   CLK,
  input  logic                   RESET,
  box_overlay_renderer_if.slave  bus
);

  localparam logic signed [11:0] MARGIN_S  = 12'(MARGIN);
  localparam logic [7:0]         ACQ_LAST  = 8'(ACQ_FRAMES - 1);
  localparam logic [7:0]         MISS_LAST = 8'(LOST_FRAMES - 1);

  trk_state_t state;
  logic [7:0] acq_cnt;
  logic [7:0] miss_cnt;
  box_t       shadow;
  logic       shadow_vld;
  box_t       active;
  box_t       win;
  logic       tracking_q;
  logic [9:0] red_q;
  logic [9:0] green_q;
  logic [9:0] blue_q;

  box_t       box_in;
  box_t       win_shadow;
  logic       commit;
  logic       frame_valid;
  logic       border_hit;
  logic       outside;
  logic [9:0] pix_r;
  logic [9:0] pix_g;
  logic [9:0] pix_b;

  assign box_in      = {bus.box_tlx, bus.box_tly, bus.box_brx, bus.box_bry};
  assign commit      = (bus.DrawX == 10'd0) && (bus.DrawY == COMMIT_Y);
  // Judged on the shadow as it stood before this cycle; a coincident strobe
  // lands in the shadow and is judged at the next commit.
  assign frame_valid = shadow_vld && box_ok(shadow);
  assign win_shadow  = win_of(shadow, MARGIN_S);
  assign outside     = (bus.DrawX >= H_ACTIVE) || (bus.DrawY >= V_ACTIVE);

  box_border_detect #(.THICK(THICK)) u_border (
    .box (active),
    .x   (bus.DrawX),
    .y   (bus.DrawY),
    .hit (border_hit)
  );

  // Colour select, lowest priority first so later assignments win.
  always_comb begin
    pix_r = bus.VGA_R;
    pix_g = bus.VGA_G;
    pix_b = bus.VGA_B;
    if ((DEBUG_EN != 0) && bus.detect) begin
      pix_r = C_ZERO;
      pix_g = C_ZERO;
      pix_b = C_FULL;
    end
    if ((state != SEARCH) && border_hit) begin
      pix_r = (state == COAST) ? C_FULL : C_ZERO;
      pix_g = C_FULL;
      pix_b = C_ZERO;
    end
    if (outside) begin
      pix_r = C_ZERO;
      pix_g = C_ZERO;
      pix_b = C_ZERO;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= SEARCH;
      acq_cnt    <= '0;
      miss_cnt   <= '0;
      shadow     <= '0;
      shadow_vld <= 1'b0;
      active     <= '0;
      win        <= WIN_FULL;
      tracking_q <= 1'b0;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
    end else begin
      red_q   <= pix_r;
      green_q <= pix_g;
      blue_q  <= pix_b;

      if (bus.box_we) begin
        shadow     <= box_in;
        shadow_vld <= 1'b1;
      end else if (commit) begin
        shadow_vld <= 1'b0;
      end

      if (commit) begin
        case (state)
          SEARCH: begin
            if (frame_valid) begin
              if (acq_cnt == ACQ_LAST) begin
                state      <= TRACK;
                acq_cnt    <= '0;
                active     <= shadow;
                win        <= win_shadow;
                tracking_q <= 1'b1;
              end else begin
                acq_cnt <= acq_cnt + 8'd1;
              end
            end else begin
              acq_cnt <= '0;
            end
          end
          TRACK: begin
            if (frame_valid) begin
              active <= shadow;
              win    <= win_shadow;
            end else begin
              state    <= COAST;
              miss_cnt <= 8'd1;
            end
          end
          COAST: begin
            if (frame_valid) begin
              state    <= TRACK;
              miss_cnt <= '0;
              active   <= shadow;
              win      <= win_shadow;
            end else if (miss_cnt == MISS_LAST) begin
              // This miss is number LOST_FRAMES: give up and search the full frame.
              state      <= SEARCH;
              miss_cnt   <= '0;
              acq_cnt    <= '0;
              win        <= WIN_FULL;
              tracking_q <= 1'b0;
            end else begin
              miss_cnt <= miss_cnt + 8'd1;
            end
          end
          default: begin
            state      <= SEARCH;
            acq_cnt    <= '0;
            miss_cnt   <= '0;
            win        <= WIN_FULL;
            tracking_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.Red      = red_q;
  assign bus.Green    = green_q;
  assign bus.Blue     = blue_q;
  assign bus.Tlx      = win.tlx;
  assign bus.Tly      = win.tly;
  assign bus.Brx      = win.brx;
  assign bus.Bry      = win.bry;
  assign bus.tracking = tracking_q;

endmodule

// File: tb/tb_box_overlay_renderer.sv
// Directed bench for box_overlay_renderer: acquisition, coast/lost, clamp, invalid box, mid-frame reset.
// Latency: checks pixel colour one CLK after the pixel is presented.
// Backpressure: none exercised; the DUT has none.
module tb_box_overlay_renderer;

  logic CLK;
  logic RESET;
  int   n_checks;
  int   n_fail;

  box_overlay_renderer_if bus();

  box_overlay_renderer dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change 1 time unit after a rising edge, outputs are sampled there too.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rgb(input string tag, input logic [9:0] r, input logic [9:0] g, input logic [9:0] b);
    chk({tag, ".R"}, bus.Red, r);
    chk({tag, ".G"}, bus.Green, g);
    chk({tag, ".B"}, bus.Blue, b);
  endtask

  task automatic chk_win(input string tag, input logic [9:0] a, input logic [9:0] b,
                         input logic [9:0] c, input logic [9:0] d);
    chk({tag, ".Tlx"}, bus.Tlx, a);
    chk({tag, ".Tly"}, bus.Tly, b);
    chk({tag, ".Brx"}, bus.Brx, c);
    chk({tag, ".Bry"}, bus.Bry, d);
  endtask

  task automatic chk_trk(input string tag, input logic exp);
    chk(tag, {9'd0, bus.tracking}, {9'd0, exp});
  endtask

  task automatic pix(input logic [9:0] x, input logic [9:0] y);
    bus.DrawX = x;
    bus.DrawY = y;
    step();
  endtask

  task automatic strobe(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c, input logic [9:0] d);
    bus.box_tlx = a;
    bus.box_tly = b;
    bus.box_brx = c;
    bus.box_bry = d;
    bus.box_we  = 1'b1;
    step();
    bus.box_we  = 1'b0;
  endtask

  task automatic commit();
    bus.DrawX = 10'd0;
    bus.DrawY = 10'd480;
    step();
    bus.DrawX = 10'd10;
    bus.DrawY = 10'd10;
  endtask

  task automatic frame(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c, input logic [9:0] d);
    strobe(a, b, c, d);
    commit();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RESET       = 1'b1;
    bus.DrawX   = 10'd10;
    bus.DrawY   = 10'd10;
    bus.VGA_R   = 10'd0;
    bus.VGA_G   = 10'd0;
    bus.VGA_B   = 10'd0;
    bus.detect  = 1'b0;
    bus.box_we  = 1'b0;
    bus.box_tlx = 10'd0;
    bus.box_tly = 10'd0;
    bus.box_brx = 10'd0;
    bus.box_bry = 10'd0;
    step();
    step();
    chk_rgb("reset_rgb", 10'd0, 10'd0, 10'd0);
    chk_win("reset_win", 10'd5, 10'd5, 10'd634, 10'd474);
    chk_trk("reset_trk", 1'b0);

    // Camera passthrough after reset.
    RESET     = 1'b0;
    bus.VGA_R = 10'd100;
    bus.VGA_G = 10'd200;
    bus.VGA_B = 10'd300;
    pix(10'd10, 10'd10);
    chk_rgb("passthru", 10'd100, 10'd200, 10'd300);
    chk_win("search_win", 10'd5, 10'd5, 10'd634, 10'd474);
    chk_trk("search_trk", 1'b0);

    // Outside the active area is black.
    pix(10'd700, 10'd10);
    chk_rgb("outside_x", 10'd0, 10'd0, 10'd0);
    // Debug blue for detected pixels.
    bus.detect = 1'b1;
    pix(10'd320, 10'd220);
    chk_rgb("detect_blue", 10'd0, 10'd0, 10'd1023);
    bus.detect = 1'b0;

    // Acquisition: V,V,I restarts the count; then three more valid frames.
    frame(10'd300, 10'd200, 10'd340, 10'd240);
    frame(10'd300, 10'd200, 10'd340, 10'd240);
    commit();
    frame(10'd300, 10'd200, 10'd340, 10'd240);
    frame(10'd300, 10'd200, 10'd340, 10'd240);
    chk_trk("acq_restart", 1'b0);
    frame(10'd300, 10'd200, 10'd340, 10'd240);
    chk_trk("acq_done", 1'b1);
    chk_win("track_win", 10'd284, 10'd184, 10'd356, 10'd256);
    pix(10'd300, 10'd220);
    chk_rgb("left_edge_green", 10'd0, 10'd1023, 10'd0);
    pix(10'd320, 10'd220);
    chk_rgb("interior_cam", 10'd100, 10'd200, 10'd300);
    pix(10'd338, 10'd220);
    chk_rgb("right_inner_cam", 10'd100, 10'd200, 10'd300);
    pix(10'd339, 10'd220);
    chk_rgb("right_edge_green", 10'd0, 10'd1023, 10'd0);
    pix(10'd341, 10'd220);
    chk_rgb("right_outside_cam", 10'd100, 10'd200, 10'd300);
    // Outline has priority over the debug blue.
    bus.detect = 1'b1;
    pix(10'd320, 10'd201);
    chk_rgb("top_edge_over_detect", 10'd0, 10'd1023, 10'd0);
    bus.detect = 1'b0;

    // One missed frame -> COAST (yellow), valid frame -> TRACK (green).
    commit();
    chk_trk("coast_trk", 1'b1);
    pix(10'd300, 10'd220);
    chk_rgb("coast_yellow", 10'd1023, 10'd1023, 10'd0);
    frame(10'd300, 10'd200, 10'd340, 10'd240);
    pix(10'd300, 10'd220);
    chk_rgb("retrack_green", 10'd0, 10'd1023, 10'd0);

    // Strobe coincident with commit: old (empty) shadow judged -> COAST,
    // captured box is judged at the next commit -> TRACK.
    bus.box_tlx = 10'd300;
    bus.box_tly = 10'd200;
    bus.box_brx = 10'd340;
    bus.box_bry = 10'd240;
    bus.box_we  = 1'b1;
    commit();
    bus.box_we  = 1'b0;
    pix(10'd300, 10'd220);
    chk_rgb("coincident_coast", 10'd1023, 10'd1023, 10'd0);
    commit();
    pix(10'd300, 10'd220);
    chk_rgb("coincident_capture", 10'd0, 10'd1023, 10'd0);

    // Window clamp at the frame edges.
    frame(10'd2, 10'd3, 10'd20, 10'd470);
    chk_win("clamp_win", 10'd5, 10'd5, 10'd36, 10'd474);
    pix(10'd2, 10'd100);
    chk_rgb("clamp_box_green", 10'd0, 10'd1023, 10'd0);

    // tlx > brx is invalid: COAST, active box and window kept.
    frame(10'd500, 10'd10, 10'd480, 10'd40);
    chk_trk("inv_trk", 1'b1);
    chk_win("inv_win_kept", 10'd5, 10'd5, 10'd36, 10'd474);
    pix(10'd2, 10'd100);
    chk_rgb("inv_yellow", 10'd1023, 10'd1023, 10'd0);

    // Back to TRACK, then 8 degenerate frames -> SEARCH on the 8th.
    frame(10'd300, 10'd200, 10'd340, 10'd240);
    for (int i = 0; i < 7; i++) frame(10'd0, 10'd0, 10'd0, 10'd0);
    chk_trk("lost_7", 1'b1);
    frame(10'd0, 10'd0, 10'd0, 10'd0);
    chk_trk("lost_8", 1'b0);
    chk_win("lost_win", 10'd5, 10'd5, 10'd634, 10'd474);
    pix(10'd300, 10'd220);
    chk_rgb("lost_no_outline", 10'd100, 10'd200, 10'd300);

    // Re-acquire, then reset mid-frame on the bottom edge.
    for (int i = 0; i < 3; i++) frame(10'd300, 10'd200, 10'd340, 10'd240);
    chk_trk("reacq", 1'b1);
    pix(10'd300, 10'd240);
    chk_rgb("bottom_edge_green", 10'd0, 10'd1023, 10'd0);
    RESET = 1'b1;
    step();
    chk_rgb("midreset_rgb", 10'd0, 10'd0, 10'd0);
    chk_trk("midreset_trk", 1'b0);
    chk_win("midreset_win", 10'd5, 10'd5, 10'd634, 10'd474);
    RESET = 1'b0;
    bus.detect = 1'b1;
    pix(10'd300, 10'd220);
    chk_rgb("post_reset_blue", 10'd0, 10'd0, 10'd1023);
    bus.detect = 1'b0;
    pix(10'd300, 10'd220);
    chk_rgb("post_reset_cam", 10'd100, 10'd200, 10'd300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
